// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, instruction codes and instruction decode.
package tap_pkg;

    localparam int unsigned TAP_IR_W = 2;
    localparam int unsigned STATE_W  = 4;

    // Standard 1149.1 state encoding
    typedef enum logic [STATE_W-1:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [TAP_IR_W-1:0] EXTEST  = 2'b00;
    localparam logic [TAP_IR_W-1:0] SAMPLE  = 2'b01;
    localparam logic [TAP_IR_W-1:0] INTSCAN = 2'b10;
    localparam logic [TAP_IR_W-1:0] BYPASS  = 2'b11;

    typedef enum logic [1:0] {
        DR_BSR = 2'd0,
        DR_INT = 2'd1,
        DR_BYP = 2'd2
    } dr_src_e;

    typedef struct packed {
        logic    hold;
        logic    bistsel;
        dr_src_e dr_src;
    } inst_dec_t;

    // RUNBIST shares the BYPASS code and is only active in RTI
    function automatic inst_dec_t inst_decode(input logic [TAP_IR_W-1:0] inst,
                                              input logic                in_rti);
        inst_dec_t d;
        d.hold    = 1'b0;
        d.bistsel = 1'b0;
        d.dr_src  = DR_BSR;
        case (inst)
            EXTEST:  d.hold = 1'b1;
            SAMPLE:  d.hold = 1'b0;
            INTSCAN: begin
                d.hold   = 1'b1;
                d.dr_src = DR_INT;
            end
            BYPASS: begin
                d.dr_src  = DR_BYP;
                d.bistsel = in_rti;
            end
            default: d.hold = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tap_ctrl_if.sv
// Pin-side and scan-chain-side signals of the TAP controller.
interface tap_ctrl_if
    import tap_pkg::*;
#(
    parameter int unsigned IR_W = TAP_IR_W
);
    logic            TMS;
    logic            TDI;
    logic [IR_W-1:0] inst;
    logic            ir_tdo;
    logic            bsr_tdo;
    logic            int_tdo;

    logic            clockdr;
    logic            shiftdr;
    logic            updatedr;
    logic            clockir;
    logic            shiftir;
    logic            updateir;
    logic            hold;
    logic            bistsel;
    logic            tlr;
    logic            TDO;
    logic            tdo_en;

    modport master (
        output TMS, TDI, inst, ir_tdo, bsr_tdo, int_tdo,
        input  clockdr, shiftdr, updatedr, clockir, shiftir, updateir,
               hold, bistsel, tlr, TDO, tdo_en
    );

    modport slave (
        input  TMS, TDI, inst, ir_tdo, bsr_tdo, int_tdo,
        output clockdr, shiftdr, updatedr, clockir, shiftir, updateir,
               hold, bistsel, tlr, TDO, tdo_en
    );

endinterface

// File: rtl/tap_fsm.sv
// 16-state 1149.1 TAP state machine, advanced by TMS on the rising test clock.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_nxt;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            TLR:    state_nxt = tms ? TLR    : RTI;
            RTI:    state_nxt = tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = tms ? UPD_DR : PA_DR;
            PA_DR:  state_nxt = tms ? EX2_DR : PA_DR;
            EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tms ? SEL_DR : RTI;
            SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
            CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = tms ? UPD_IR : PA_IR;
            PA_IR:  state_nxt = tms ? EX2_IR : PA_IR;
            EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tms ? SEL_DR : RTI;
        endcase
    end

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller: strobe gating, instruction decode, bypass register and TDO mux.
module tap_ctrl
    import tap_pkg::*;
#(
    parameter int unsigned     IR_W       = TAP_IR_W,
    parameter logic [IR_W-1:0] RESET_INST = BYPASS
)(
    input logic       TCK,
    input logic       TRST,
    tap_ctrl_if.slave bus
);

    tap_state_e      state;
    logic [IR_W-1:0] eff_inst;
    inst_dec_t       dec;
    logic            cen_dr;
    logic            cen_ir;
    logic            shiftdr_q;
    logic            shiftir_q;
    logic            tdo_q;
    logic            tdo_en_q;
    logic            bypass_q;
    logic            dr_tdo;

    tap_fsm u_fsm (
        .tck   (TCK),
        .trst  (TRST),
        .tms   (bus.TMS),
        .state (state)
    );

    assign eff_inst = (state == TLR) ? RESET_INST : bus.inst;
    assign dec      = inst_decode(eff_inst, state == RTI);

    // Falling-edge controls so the gated strobes only change while TCK is low
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            shiftdr_q <= 1'b0;
            shiftir_q <= 1'b0;
            cen_dr    <= 1'b0;
            cen_ir    <= 1'b0;
            tdo_en_q  <= 1'b0;
            tdo_q     <= 1'b0;
        end else begin
            shiftdr_q <= (state == SH_DR);
            shiftir_q <= (state == SH_IR);
            cen_dr    <= (state == CAP_DR) || (state == SH_DR);
            cen_ir    <= (state == CAP_IR) || (state == SH_IR);
            tdo_en_q  <= (state == SH_DR) || (state == SH_IR);
            if (state == SH_IR) begin
                tdo_q <= bus.ir_tdo;
            end else if (state == SH_DR) begin
                tdo_q <= dr_tdo;
            end
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            bypass_q <= 1'b0;
        end else if (state == CAP_DR) begin
            bypass_q <= 1'b0;
        end else if (state == SH_DR) begin
            bypass_q <= bus.TDI;
        end
    end

    // Data-register serial output selected by the effective instruction
    always_comb begin
        dr_tdo = bus.bsr_tdo;
        case (dec.dr_src)
            DR_INT:  dr_tdo = bus.int_tdo;
            DR_BYP:  dr_tdo = bypass_q;
            default: dr_tdo = bus.bsr_tdo;
        endcase
    end

    assign bus.clockdr  = TCK & cen_dr;
    assign bus.clockir  = TCK & cen_ir;
    assign bus.updatedr = ~TCK & (state == UPD_DR);
    assign bus.updateir = ~TCK & (state == UPD_IR);
    assign bus.shiftdr  = shiftdr_q;
    assign bus.shiftir  = shiftir_q;
    assign bus.hold     = dec.hold;
    assign bus.bistsel  = dec.bistsel;
    assign bus.tlr      = (state == TLR);
    assign bus.TDO      = tdo_q;
    assign bus.tdo_en   = tdo_en_q;

endmodule

// File: tb/tb_tap_ctrl.sv
// Scoreboard bench for tap_ctrl: per-cycle expected status and TDO bits are queued, a monitor compares.
module tb_tap_ctrl;
    import tap_pkg::*;

    logic TCK = 1'b0;
    logic TRST;
    logic sdo;

    tap_ctrl_if #(.IR_W(TAP_IR_W)) bus ();

    tap_ctrl #(.IR_W(TAP_IR_W), .RESET_INST(BYPASS)) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus.slave)
    );

    always #5 TCK = ~TCK;

    assign bus.ir_tdo  = sdo;
    assign bus.int_tdo = sdo;
    assign bus.bsr_tdo = ~sdo;

    typedef struct packed {
        logic [3:0] state;
        logic       tlr;
        logic       hold;
        logic       bistsel;
        logic       shiftdr;
        logic       shiftir;
        logic       tdo_en;
    } rec_t;

    rec_t       rec_q [$];
    logic       tdo_q [$];
    int         checks   = 0;
    int         failures = 0;
    tap_state_e m_state;

    int n_clockdr  = 0;
    int n_clockir  = 0;
    int n_updatedr = 0;
    int n_updateir = 0;
    int n_shiftir  = 0;

    always @(posedge bus.clockdr)  n_clockdr++;
    always @(posedge bus.clockir)  n_clockir++;
    always @(posedge bus.updatedr) n_updatedr++;
    always @(posedge bus.updateir) n_updateir++;
    always @(posedge TCK) if (bus.shiftir) n_shiftir++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tap_state_e m_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:     return tms ? TLR    : RTI;
            RTI:     return tms ? SEL_DR : RTI;
            SEL_DR:  return tms ? SEL_IR : CAP_DR;
            CAP_DR:  return tms ? EX1_DR : SH_DR;
            SH_DR:   return tms ? EX1_DR : SH_DR;
            EX1_DR:  return tms ? UPD_DR : PA_DR;
            PA_DR:   return tms ? EX2_DR : PA_DR;
            EX2_DR:  return tms ? UPD_DR : SH_DR;
            UPD_DR:  return tms ? SEL_DR : RTI;
            SEL_IR:  return tms ? TLR    : CAP_IR;
            CAP_IR:  return tms ? EX1_IR : SH_IR;
            SH_IR:   return tms ? EX1_IR : SH_IR;
            EX1_IR:  return tms ? UPD_IR : PA_IR;
            PA_IR:   return tms ? EX2_IR : PA_IR;
            EX2_IR:  return tms ? UPD_IR : SH_IR;
            UPD_IR:  return tms ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

    function automatic rec_t exp_rec(input tap_state_e s, input logic [1:0] ins);
        rec_t r;
        r.state   = s;
        r.tlr     = (s == TLR);
        r.hold    = (s != TLR) && ((ins == 2'b00) || (ins == 2'b10));
        r.bistsel = (s == RTI) && (ins == 2'b11);
        r.shiftdr = (s == SH_DR);
        r.shiftir = (s == SH_IR);
        r.tdo_en  = (s == SH_DR) || (s == SH_IR);
        return r;
    endfunction

    // One TCK cycle: drive, queue the expectation for the following falling edge
    task automatic step(input logic tms, input logic tdi, input logic so);
        bus.TMS = tms;
        bus.TDI = tdi;
        sdo     = so;
        @(posedge TCK);
        m_state = m_next(m_state, tms);
        rec_q.push_back(exp_rec(m_state, bus.inst));
        if (m_state == SH_IR) begin
            tdo_q.push_back(so);
        end else if (m_state == SH_DR && bus.inst != 2'b11) begin
            tdo_q.push_back((bus.inst == 2'b10) ? so : ~so);
        end
        @(negedge TCK);
        #2;
    endtask

    initial begin : monitor
        rec_t e;
        rec_t a;
        logic t;
        forever begin
            @(negedge TCK);
            #1;
            if (rec_q.size() > 0) begin
                e = rec_q.pop_front();
                a.state   = dut.u_fsm.state;
                a.tlr     = bus.tlr;
                a.hold    = bus.hold;
                a.bistsel = bus.bistsel;
                a.shiftdr = bus.shiftdr;
                a.shiftir = bus.shiftir;
                a.tdo_en  = bus.tdo_en;
                check("cycle_status", 32'(a), 32'(e));
            end
            if (bus.tdo_en === 1'b1) begin
                if (tdo_q.size() == 0) begin
                    check("tdo_unexpected", 32'(bus.TDO), 32'hFFFF_FFFF);
                end else begin
                    t = tdo_q.pop_front();
                    check("tdo_bit", 32'(bus.TDO), 32'(t));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    int         plen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [7:0] pval [16] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h0A, 8'h15,
                              8'h0B, 8'h03, 8'h06, 8'h0C, 8'h0D, 8'h1A, 8'h35, 8'h1B};
    tap_state_e ptgt [16] = '{TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR,
                              UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR};

    initial begin : stim
        logic [7:0] pv;
        int         b0;
        int         b1;
        int         b2;
        int         b3;

        TRST     = 1'b1;
        bus.TMS  = 1'b1;
        bus.TDI  = 1'b0;
        bus.inst = 2'b11;
        sdo      = 1'b0;
        m_state  = TLR;
        #12;
        check("rst_state",   32'(dut.u_fsm.state), 32'(TLR));
        check("rst_tlr",     32'(bus.tlr),     32'd1);
        check("rst_tdo_en",  32'(bus.tdo_en),  32'd0);
        check("rst_tdo",     32'(bus.TDO),     32'd0);
        check("rst_shiftdr", 32'(bus.shiftdr), 32'd0);
        check("rst_hold",    32'(bus.hold),    32'd0);
        check("rst_bistsel", 32'(bus.bistsel), 32'd0);
        @(negedge TCK);
        #2;
        TRST = 1'b0;

        // Reach every state, then five TMS=1 must land in TLR
        bus.inst = 2'b10;
        for (int i = 0; i < 16; i++) begin
            pv = pval[i] << (8 - plen[i]);
            for (int b = 0; b < plen[i]; b++) begin
                step(pv[7], 1'b0, 1'(b));
                pv = pv << 1;
            end
            check("walk_state", 32'(dut.u_fsm.state), 32'(ptgt[i]));
            for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
            check("walk_to_tlr", 32'(bus.tlr), 32'd1);
        end

        // IR scan: capture plus two shifts, one update
        bus.inst = 2'b11;
        step(1'b0, 1'b0, 1'b0);
        b0 = n_clockir; b1 = n_updateir; b2 = n_shiftir; b3 = n_clockdr + n_updatedr;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("ir_clockir_pulses",  32'(n_clockir - b0),  32'd3);
        check("ir_updateir_pulses", 32'(n_updateir - b1), 32'd1);
        check("ir_shiftir_cycles",  32'(n_shiftir - b2),  32'd2);
        check("ir_no_dr_strobes",   32'(n_clockdr + n_updatedr - b3), 32'd0);

        // BYPASS: TDI 1,0,1,1 comes out as 0,1,0,1
        check("rti_bistsel", 32'(bus.bistsel), 32'd1);
        b1 = n_updatedr;
        tdo_q.push_back(1'b0);
        tdo_q.push_back(1'b1);
        tdo_q.push_back(1'b0);
        tdo_q.push_back(1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("byp_updatedr_pulses", 32'(n_updatedr - b1), 32'd1);

        // Pause mid-shift: no DR clocks, the shifted-in 1 survives
        tdo_q.push_back(1'b0);
        tdo_q.push_back(1'b1);
        tdo_q.push_back(1'b1);
        tdo_q.push_back(1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        b0 = n_clockdr;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("pause_no_clockdr", 32'(n_clockdr - b0), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // EXTEST: hold outside TLR, DR reads the boundary chain
        bus.inst = 2'b00;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("extest_hold_rti", 32'(bus.hold), 32'd1);

        // INTSCAN: DR reads the internal chain
        bus.inst = 2'b10;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        bus.inst = 2'b00;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
        check("extest_hold_tlr", 32'(bus.hold), 32'd0);

        // TRST while shifting with TCK high
        bus.inst = 2'b11;
        step(1'b0, 1'b0, 1'b0);
        tdo_q.push_back(1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        b1 = n_updatedr;
        bus.TMS = 1'b0;
        @(posedge TCK);
        #2;
        check("pre_rst_clockdr", 32'(bus.clockdr), 32'd1);
        TRST = 1'b1;
        #1;
        check("trst_state",   32'(dut.u_fsm.state), 32'(TLR));
        check("trst_clockdr", 32'(bus.clockdr), 32'd0);
        check("trst_shiftdr", 32'(bus.shiftdr), 32'd0);
        check("trst_tdo_en",  32'(bus.tdo_en),  32'd0);
        #1;
        bus.TMS = 1'b1;
        TRST    = 1'b0;
        @(negedge TCK);
        #2;
        m_state = TLR;
        step(1'b1, 1'b0, 1'b0);
        check("trst_no_updatedr", 32'(n_updatedr - b1), 32'd0);
        check("trst_stay_tlr",    32'(bus.tlr), 32'd1);

        check("rec_q_drained", 32'(rec_q.size()), 32'd0);
        check("tdo_q_drained", 32'(tdo_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tap_ctrl.md
Name: tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller for the scan infrastructure.
- Sequences the boundary-scan cells, the internal scan cells and the 2-bit instruction register via TMS.
- Generates the capture/shift/update strobes and the hold/bist mode selects, owns the 1-bit bypass register, and muxes the final TDO.
- Sits at chip top, between the TAP pins and the scan chains.

Parameters:
- IR_W, 2, instruction register width; must match the instruction register block.
- RESET_INST, 2'b11, instruction value forced while in TEST_LOGIC_RESET (BYPASS).

Ports:
- TCK  in  1  test clock; the only clock.
- TRST  in  1  asynchronous, active-high reset.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial in; feeds the bypass register.
- inst  in  IR_W  decoded instruction from the instruction register update stage.
- ir_tdo  in  1  instruction register serial out.
- bsr_tdo  in  1  boundary scan chain serial out.
- int_tdo  in  1  internal scan chain serial out.
- clockdr  out  1  gated DR capture/shift clock.
- shiftdr  out  1  DR shift select.
- updatedr  out  1  DR update clock.
- clockir  out  1  gated IR capture/shift clock.
- shiftir  out  1  IR shift select.
- updateir  out  1  IR update clock.
- hold  out  1  test-output select for scan cells.
- bistsel  out  1  BIST/LFSR mode select.
- tlr  out  1  high while in TEST_LOGIC_RESET.
- TDO  out  1  serial out.
- tdo_en  out  1  TDO drive enable.

Behaviour:
- State register: 16 states, updated on posedge TCK from TMS using the standard 1149.1 graph: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- Selected transitions:
  - TLR: TMS=0 -> RTI.
  - SEL_IR: TMS=1 -> TLR.
  - UPD_x: TMS=1 -> SEL_DR, TMS=0 -> RTI.
  - EX2_x: TMS=0 -> SH_x.
- Reset: TRST=1 forces state=TLR immediately (asynchronous). Every negedge-updated register also clears: shiftdr=0, shiftir=0, TDO=0, tdo_en=0, bypass=0.
- Five consecutive TMS=1 posedges reach TLR from any state.
- Falling-edge registers (negedge TCK, same clock):
  - shiftdr <= (state==SH_DR); shiftir <= (state==SH_IR).
  - tdo_en <= state in {SH_DR, SH_IR}.
  - cen_dr <= state in {CAP_DR, SH_DR}; cen_ir likewise for the IR states.
- Strobes, glitch-free:
  - clockdr = TCK & cen_dr, so the rising edge falls on the posedge TCK that leaves CAP_DR or SH_DR. clockir likewise.
  - updatedr = ~TCK & (state==UPD_DR), giving one rising edge at the negedge in UPD_DR. updateir likewise.
  - In TLR all strobes are 0.
- Instruction effect uses eff_inst = (state==TLR) ? RESET_INST : inst.
  - 00 EXTEST: hold=1, bistsel=0, DR=BSR.
  - 01 SAMPLE: hold=0, bistsel=0, DR=BSR.
  - 10 INTSCAN: hold=1, bistsel=0, DR=internal chain.
  - 11 BYPASS: hold=0, bistsel=0, DR=bypass. RUNBIST is the same code with bistsel=1, asserted only while in RTI.
  - hold, bistsel and tlr are combinational from eff_inst and state, and are 0/safe in TLR.
- Bypass register:
  - posedge TCK: CAP_DR loads 0; SH_DR loads TDI; otherwise holds.
  - Only meaningful when eff_inst=11.
- TDO (negedge TCK):
  - SH_IR: ir_tdo.
  - SH_DR: DR mux output.
  - Otherwise holds the last value, with tdo_en=0.
  - One-bit latency: TDI at posedge n appears on TDO at negedge n in BYPASS.
- Pause states hold all strobes low and shift selects low; chain contents are preserved.
- TRST asserted mid-shift: strobes drop within the same TCK phase, no update strobe is emitted, state=TLR.

Decomposition:
- Shared package tap_pkg:
  - 4-bit state enum, with constants for all 16 states.
  - Instruction code constants: EXTEST, SAMPLE, INTSCAN, BYPASS.
- One sub-module: tap_fsm, holding the state register plus next-state logic. Strobe gating, decode, bypass and the TDO mux stay in tap_ctrl.

Test Plan:
- TRST=1 mid-SH_DR -> state=TLR, clockdr=0, shiftdr=0, tdo_en=0 immediately; release with TMS=1 -> stays TLR.
- From RTI, TMS 1,1,1,1,1 -> TLR after exactly 5 posedges, regardless of start state; check from each of the 16 states.
- Scan in IR via TMS 1,1,0,0 then two SH_IR cycles then 1,1 -> exactly 3 clockir pulses (1 capture + 2 shift), exactly 1 updateir pulse, shiftir=1 for 2 negedge intervals.
- inst=11, enter SH_DR, TDI stream 1,0,1,1 -> TDO 0,1,0,1 with 1-cycle delay; first bit out is the captured 0.
- inst=00 -> hold=1 outside TLR, hold=0 in TLR. inst=10 with a DR shift -> TDO follows int_tdo.
- Entering PA_DR from EX1_DR with TMS=0 for 3 cycles, then EX2_DR -> SH_DR -> no clockdr edges during pause, shifting resumes with the chain intact.
